// File: rtl/sim_memory_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sim_memory_port_arbiter_if
// Brief    : Request/response channel shared by requesters and the memory model
// Revision : 1.0 - initial release
// ============================================================================
interface sim_memory_port_arbiter_if;
    logic        req;
    logic        lock;
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [25:0] addr;
    logic [31:0] data;
    logic        rsp_valid;
    logic        rsp_lock;
    logic [63:0] rsp_data;

    // The master issues requests and consumes responses.
    modport master (
        output req, order, mask, rw, addr, data, rsp_lock,
        input  lock, rsp_valid, rsp_data
    );

    modport slave (
        input  req, order, mask, rw, addr, data, rsp_lock,
        output lock, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/sim_memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sim_memory_port_arbiter
// Brief    : Round-robin two-port arbiter with in-order read response routing
// Revision : 1.0 - initial release
// ============================================================================
module sim_memory_port_arbiter #(
    parameter int P_TAG_DEPTH   = 8,
    parameter int P_TAG_DEPTH_N = 3,
    parameter int P_PRIO_INIT   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    sim_memory_port_arbiter_if.slave         p0,
    sim_memory_port_arbiter_if.slave         p1,
    sim_memory_port_arbiter_if.master        mem,
    output logic [P_TAG_DEPTH_N:0]           outstanding,
    output logic                             orphan_err
);

    localparam logic [P_TAG_DEPTH_N:0] c_full = (P_TAG_DEPTH_N+1)'(P_TAG_DEPTH);

    logic                       r_prio;
    logic [P_TAG_DEPTH_N:0]     r_count;
    logic [P_TAG_DEPTH_N-1:0]   r_wr_ptr;
    logic [P_TAG_DEPTH_N-1:0]   r_rd_ptr;
    logic [P_TAG_DEPTH-1:0]     r_tags;
    logic                       r_orphan;

    logic w_winner;
    logic w_win_req;
    logic w_win_rw;
    logic w_blk;
    logic w_accept;
    logic w_push;
    logic w_nonempty;
    logic w_head;
    logic w_pop;

    // ------------------------------------------------------------------
    // Request side: pick a winner and forward its fields unregistered
    // ------------------------------------------------------------------
    always_comb begin
        w_winner = r_prio;
        if (p0.req && !p1.req) begin
            w_winner = 1'b0;
        end else if (p1.req && !p0.req) begin
            w_winner = 1'b1;
        end
    end

    always_comb begin
        w_win_req = p0.req;
        w_win_rw  = p0.rw;
        mem.order = p0.order;
        mem.mask  = p0.mask;
        mem.rw    = p0.rw;
        mem.addr  = p0.addr;
        mem.data  = p0.data;
        if (w_winner) begin
            w_win_req = p1.req;
            w_win_rw  = p1.rw;
            mem.order = p1.order;
            mem.mask  = p1.mask;
            mem.rw    = p1.rw;
            mem.addr  = p1.addr;
            mem.data  = p1.data;
        end
    end

    // A full tag FIFO blocks reads even if a response pops this cycle,
    // which keeps the accept path independent of iMEM_VALID.
    assign w_blk    = !w_win_rw && (r_count == c_full);
    assign mem.req  = w_win_req && !w_blk;
    assign w_accept = mem.req && !mem.lock;
    assign w_push   = w_accept && !w_win_rw;

    assign p0.lock = p0.req && !(!w_winner && w_accept);
    assign p1.lock = p1.req && !( w_winner && w_accept);

    // ------------------------------------------------------------------
    // Response side: route by the oldest outstanding tag
    // ------------------------------------------------------------------
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_tags[r_rd_ptr];

    always_comb begin
        mem.rsp_lock = 1'b0;
        if (w_nonempty) begin
            mem.rsp_lock = w_head ? p1.rsp_lock : p0.rsp_lock;
        end
    end

    assign w_pop = mem.rsp_valid && w_nonempty && !mem.rsp_lock;

    assign p0.rsp_valid = mem.rsp_valid && w_nonempty && !w_head;
    assign p1.rsp_valid = mem.rsp_valid && w_nonempty &&  w_head;
    assign p0.rsp_data  = mem.rsp_data;
    assign p1.rsp_data  = mem.rsp_data;

    assign outstanding = r_count;
    assign orphan_err  = r_orphan;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= (P_PRIO_INIT != 0);
        end else if (w_accept) begin
            r_prio <= !w_winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wr_ptr] <= w_winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_orphan <= 1'b0;
        end else if (mem.rsp_valid && !w_nonempty) begin
            r_orphan <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sim_memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_memory_port_arbiter
// Brief    : Directed bench with a small behavioural memory model
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_memory_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] outstanding;
    logic orphan_err;

    int n_checks = 0;
    int n_fail   = 0;

    sim_memory_port_arbiter_if p0_if ();
    sim_memory_port_arbiter_if p1_if ();
    sim_memory_port_arbiter_if mem_if ();

    sim_memory_port_arbiter #(
        .P_TAG_DEPTH   (8),
        .P_TAG_DEPTH_N (3),
        .P_PRIO_INIT   (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p0          (p0_if),
        .p1          (p1_if),
        .mem         (mem_if),
        .outstanding (outstanding),
        .orphan_err  (orphan_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Memory model: 64 lines of 64 bits, 8-deep response FIFO
    // ------------------------------------------------------------------
    logic [63:0] mem_arr [0:63];
    logic [63:0] rq      [0:7];
    logic [2:0]  rq_rd;
    logic [2:0]  rq_wr;
    int          rq_cnt;
    logic        mem_busy    = 1'b0;
    logic        force_valid = 1'b0;

    function automatic logic [63:0] line_val(input int i);
        return 64'hA5A5_0000_0000_0000 + 64'(i);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic hi,
                                          input logic [3:0] m, input logic [31:0] d);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[(hi ? 32 : 0) + 8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    assign mem_if.lock      = mem_busy || (rq_cnt == 8);
    assign mem_if.rsp_valid = (rq_cnt != 0) || force_valid;
    assign mem_if.rsp_data  = rq[rq_rd];

    always @(posedge clk) begin
        if (rst) begin
            rq_cnt <= 0;
            rq_rd  <= '0;
            rq_wr  <= '0;
            for (int i = 0; i < 64; i++) mem_arr[i] <= line_val(i);
        end else begin
            if (mem_if.req && !mem_if.lock && mem_if.rw)
                mem_arr[mem_if.addr[8:3]] <= merge(mem_arr[mem_if.addr[8:3]], mem_if.addr[2],
                                                   mem_if.mask, mem_if.data);
            if (mem_if.req && !mem_if.lock && !mem_if.rw) begin
                rq[rq_wr] <= mem_arr[mem_if.addr[8:3]];
                rq_wr     <= rq_wr + 3'd1;
            end
            if ((rq_cnt != 0) && !mem_if.rsp_lock) rq_rd <= rq_rd + 3'd1;
            rq_cnt <= rq_cnt + ((mem_if.req && !mem_if.lock && !mem_if.rw) ? 1 : 0)
                             - (((rq_cnt != 0) && !mem_if.rsp_lock) ? 1 : 0);
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        p0_if.req = 1'b0; p0_if.rw = 1'b0; p0_if.order = 2'b11; p0_if.mask = 4'h0;
        p0_if.addr = '0;  p0_if.data = '0;
        p1_if.req = 1'b0; p1_if.rw = 1'b0; p1_if.order = 2'b11; p1_if.mask = 4'h0;
        p1_if.addr = '0;  p1_if.data = '0;
    endtask

    task automatic drv(input int port, input logic rw, input logic [25:0] a, input logic [31:0] d);
        if (port == 0) begin
            p0_if.req = 1'b1; p0_if.rw = rw; p0_if.order = 2'b10; p0_if.mask = 4'hF;
            p0_if.addr = a;   p0_if.data = d;
        end else begin
            p1_if.req = 1'b1; p1_if.rw = rw; p1_if.order = 2'b10; p1_if.mask = 4'hF;
            p1_if.addr = a;   p1_if.data = d;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int exp_grant [4] = '{0, 1, 0, 1};

        idle();
        p0_if.rsp_lock = 1'b0;
        p1_if.rsp_lock = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_orphan",      64'(orphan_err), 64'd0);
        chk("rst_mem_req",     64'(mem_if.req), 64'd0);
        chk("rst_p0_valid",    64'(p0_if.rsp_valid), 64'd0);
        chk("rst_mem_lock",    64'(mem_if.rsp_lock), 64'd0);

        // Two reads, P0 then P1; hold P0's response a cycle to reach count 2
        @(negedge clk); rst = 1'b0; drv(0, 1'b0, 26'h0, 32'h0); #1;
        chk("t1_p0_lock", 64'(p0_if.lock), 64'd0);
        chk("t1_mem_req", 64'(mem_if.req), 64'd1);
        chk("t1_mem_addr", 64'(mem_if.addr), 64'h0);
        @(negedge clk); idle(); drv(1, 1'b0, 26'h8, 32'h0); p0_if.rsp_lock = 1'b1; #1;
        chk("t1_cnt1", 64'(outstanding), 64'd1);
        chk("t1_p0_valid", 64'(p0_if.rsp_valid), 64'd1);
        chk("t1_p0_data", p0_if.rsp_data, line_val(0));
        chk("t1_mem_lock", 64'(mem_if.rsp_lock), 64'd1);
        chk("t1_p1_lock", 64'(p1_if.lock), 64'd0);
        @(negedge clk); idle(); p0_if.rsp_lock = 1'b0; #1;
        chk("t1_cnt2", 64'(outstanding), 64'd2);
        chk("t1_p0_valid2", 64'(p0_if.rsp_valid), 64'd1);
        chk("t1_p1_novalid", 64'(p1_if.rsp_valid), 64'd0);
        @(negedge clk); #1;
        chk("t1_cnt_b", 64'(outstanding), 64'd1);
        chk("t1_p1_valid", 64'(p1_if.rsp_valid), 64'd1);
        chk("t1_p1_data", p1_if.rsp_data, line_val(1));
        chk("t1_p0_novalid", 64'(p0_if.rsp_valid), 64'd0);
        @(negedge clk); #1;
        chk("t1_cnt0", 64'(outstanding), 64'd0);
        chk("t1_idle_valid", 64'(p1_if.rsp_valid), 64'd0);

        // Both requesting writes every cycle: grants alternate
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv(0, 1'b1, 26'h100, 32'(i));
            drv(1, 1'b1, 26'h180, 32'(i));
            #1;
            chk("t2_p0_lock", 64'(p0_if.lock), 64'(exp_grant[i] == 1));
            chk("t2_p1_lock", 64'(p1_if.lock), 64'(exp_grant[i] == 0));
            chk("t2_addr", 64'(mem_if.addr), (exp_grant[i] == 0) ? 64'h100 : 64'h180);
        end

        // P0 write gives priority to P1; then P1 stalls on memory busy
        @(negedge clk); idle(); drv(0, 1'b1, 26'h1C0, 32'h1); #1;
        chk("t3_p0_accept", 64'(p0_if.lock), 64'd0);
        @(negedge clk); idle(); drv(1, 1'b1, 26'h1C8, 32'h2); mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk("t3_p1_stall", 64'(p1_if.lock), 64'd1);
            chk("t3_req_shown", 64'(mem_if.req), 64'd1);
        end
        @(negedge clk); mem_busy = 1'b0; #1;
        chk("t3_p1_accept", 64'(p1_if.lock), 64'd0);
        @(negedge clk); drv(0, 1'b1, 26'h1D0, 32'h3); #1;
        chk("t3_prio_p0", 64'(p0_if.lock), 64'd0);
        chk("t3_prio_p1", 64'(p1_if.lock), 64'd1);

        // Fill the tag FIFO with held P0 reads; the ninth must block
        @(negedge clk); idle(); p0_if.rsp_lock = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            drv(0, 1'b0, 26'(8*k), 32'h0); #1;
            chk("t4_fill_lock", 64'(p0_if.lock), 64'd0);
        end
        @(negedge clk); drv(0, 1'b0, 26'h40, 32'h0); #1;
        chk("t4_full_cnt", 64'(outstanding), 64'd8);
        chk("t4_full_lock", 64'(p0_if.lock), 64'd1);
        chk("t4_full_req", 64'(mem_if.req), 64'd0);
        @(negedge clk); p0_if.rsp_lock = 1'b0; #1;
        chk("t4_pop_lock", 64'(p0_if.lock), 64'd1);
        chk("t4_pop_req", 64'(mem_if.req), 64'd0);
        chk("t4_data0", p0_if.rsp_data, line_val(0));
        @(negedge clk); #1;
        chk("t4_cnt7", 64'(outstanding), 64'd7);
        chk("t4_ninth_ok", 64'(p0_if.lock), 64'd0);
        chk("t4_data1", p0_if.rsp_data, line_val(1));
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk); idle(); #1;
            chk("t4_valid", 64'(p0_if.rsp_valid), 64'd1);
            chk("t4_data", p0_if.rsp_data, line_val(k));
        end
        @(negedge clk); #1;
        chk("t4_drained", 64'(outstanding), 64'd0);

        // Write from P1 is visible to a P0 read in the next cycle
        @(negedge clk); idle(); drv(1, 1'b1, 26'h10, 32'hDEAD_BEEF); #1;
        chk("t5_wr_accept", 64'(p1_if.lock), 64'd0);
        @(negedge clk); idle(); drv(0, 1'b0, 26'h10, 32'h0); #1;
        chk("t5_rd_accept", 64'(p0_if.lock), 64'd0);
        @(negedge clk); idle(); #1;
        chk("t5_valid", 64'(p0_if.rsp_valid), 64'd1);
        chk("t5_lo", 64'(p0_if.rsp_data[31:0]), 64'hDEAD_BEEF);
        chk("t5_hi", 64'(p0_if.rsp_data[63:32]), 64'hA5A5_0000);

        // Reset with reads in flight, then an orphan response
        p1_if.rsp_lock = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drv(1, 1'b0, 26'(32 + 8*k), 32'h0);
        end
        @(negedge clk); idle(); #1;
        chk("t6_cnt3", 64'(outstanding), 64'd3);
        chk("t6_p1_valid", 64'(p1_if.rsp_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; p1_if.rsp_lock = 1'b0; #1;
        chk("t6_flush_cnt", 64'(outstanding), 64'd0);
        chk("t6_flush_v1", 64'(p1_if.rsp_valid), 64'd0);
        chk("t6_flush_v0", 64'(p0_if.rsp_valid), 64'd0);
        chk("t6_orphan0", 64'(orphan_err), 64'd0);
        @(negedge clk); force_valid = 1'b1; #1;
        chk("t6_forced_v1", 64'(p1_if.rsp_valid), 64'd0);
        chk("t6_forced_lock", 64'(mem_if.rsp_lock), 64'd0);
        @(negedge clk); force_valid = 1'b0; #1;
        chk("t6_orphan_set", 64'(orphan_err), 64'd1);
        @(negedge clk); #1;
        chk("t6_orphan_sticky", 64'(orphan_err), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
